// File: rtl/uc_capture_pkg.sv
// -----------------------------------------------------------------------------
// uc_capture_pkg
// Shared definitions for the RX block-capture buffer:
//   - cap_state_e : capture FSM state encoding (IDLE=0, ARMED=1, CAPTURE=2, DONE=3)
//   - depth_of()  : RAM depth for a given address width (2**aw)
//   - clamp_len() : maps a requested capture length onto 1..2**aw
//                   (0 and anything above the depth both mean "full buffer")
// -----------------------------------------------------------------------------
package uc_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned aw);
    int unsigned d;
    d = depth_of(aw);
    if ((len == 32'd0) || (len > d)) begin
      return d;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/uc_capture_ram.sv
// -----------------------------------------------------------------------------
// uc_capture_ram
// Simple dual-port sample RAM: one synchronous write port, one registered read
// port, read-first on a same-address collision. Depth 2**AW, width WW.
// Ports:
//   clk, rst_n      clock, async active-low reset (read register only)
//   we/waddr/wdata  write port
//   raddr           read address
//   rdata           registered read data (1-cycle latency, resets to 0)
// -----------------------------------------------------------------------------
module uc_capture_ram
  import uc_capture_pkg::*;
#(
  parameter int WW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [WW-1:0] rdata
);

  localparam int unsigned DEPTH = depth_of(AW);

  logic [WW-1:0] mem_q [DEPTH];
  logic [WW-1:0] rdata_d;
  logic [WW-1:0] rdata_q;

  // Storage array; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read mux; the array value seen here is the pre-write one (read-first).
  always_comb begin
    rdata_d = mem_q[raddr];
  end

  // Registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/uc_rx_capture.sv
// -----------------------------------------------------------------------------
// uc_rx_capture
// Block-capture buffer behind the RX decimator. A start pulse arms the block;
// it then stores cap_len x/y pairs (0 or >2**AW means 2**AW), keeping one
// ce_down sample in every decim+1. Software reads the buffer by address.
// Optional feature macro: UC_CAPTURE_TRIG_EN adds a level/slope trigger on
// in_x that ARMED waits for (ports trig_level, trig_slope).
// Ports:
//   sys_clk, rst_n         clock, async active-low reset
//   ce_down, in_x, in_y    decimated sample stream
//   start, abort           control pulses (abort wins over start)
//   cap_len, decim         capture length and extra decimation, latched on start
//   rd_addr -> rd_x, rd_y  CPU read port, 1-cycle latency
//   busy, done, wr_count   status (registered)
// -----------------------------------------------------------------------------
module uc_rx_capture
  import uc_capture_pkg::*;
#(
  parameter int DW   = 16,
  parameter int AW   = 10,
  parameter int DECW = 8
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 ce_down,
  input  logic signed [DW-1:0] in_x,
  input  logic signed [DW-1:0] in_y,
  input  logic                 start,
  input  logic                 abort,
  input  logic [AW:0]          cap_len,
  input  logic [DECW-1:0]      decim,
  input  logic [AW-1:0]        rd_addr,
  output logic signed [DW-1:0] rd_x,
  output logic signed [DW-1:0] rd_y,
  output logic                 busy,
  output logic                 done,
  output logic [AW:0]          wr_count
`ifdef UC_CAPTURE_TRIG_EN
  ,
  input  logic signed [DW-1:0] trig_level,
  input  logic                 trig_slope
`endif
);

  cap_state_e      state_q, state_d;
  logic [AW:0]     len_q, len_d;
  logic [DECW-1:0] decim_q, decim_d;
  logic [DECW-1:0] dec_cnt_q, dec_cnt_d;
  logic [AW:0]     wr_count_q, wr_count_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            start_s;
  logic            we_s;
  logic [2*DW-1:0] rd_data_s;

`ifdef UC_CAPTURE_TRIG_EN
  logic signed [DW-1:0] prev_x_q, prev_x_d;
  logic                 trig_hit_s;

  // Level crossing of in_x against trig_level, relative to the previous sample.
  always_comb begin
    if (trig_slope == 1'b0) begin
      trig_hit_s = (prev_x_q < trig_level) && (in_x >= trig_level);
    end else begin
      trig_hit_s = (prev_x_q > trig_level) && (in_x <= trig_level);
    end
  end
`endif

  // abort has priority over start in every state.
  assign start_s = start & ~abort;

  // Next-state, counter and write-enable logic for the capture FSM.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    decim_d    = decim_q;
    dec_cnt_d  = dec_cnt_q;
    wr_count_d = wr_count_q;
    we_s       = 1'b0;
`ifdef UC_CAPTURE_TRIG_EN
    prev_x_d   = prev_x_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_s) begin
          len_d      = (AW+1)'(clamp_len(32'(cap_len), AW));
          decim_d    = decim;
          wr_count_d = '0;
          dec_cnt_d  = '0;
          state_d    = ST_ARMED;
        end else begin
          state_d    = state_q;
        end
      end

      ST_ARMED: begin
`ifdef UC_CAPTURE_TRIG_EN
        if (ce_down) begin
          prev_x_d = in_x;
          // The crossing sample is decimation phase 0 and is stored at once.
          if (trig_hit_s) begin
            we_s       = 1'b1;
            wr_count_d = wr_count_q + (AW+1)'(1);
            dec_cnt_d  = decim_q;
            if (wr_count_d == len_q) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_CAPTURE;
            end
          end else begin
            state_d = ST_ARMED;
          end
        end else begin
          state_d = ST_ARMED;
        end
`else
        // Without a trigger ARMED is a single cycle; its ce_down is dropped.
        state_d = ST_CAPTURE;
`endif
      end

      ST_CAPTURE: begin
        if (ce_down) begin
          if (dec_cnt_q == '0) begin
            // len_q never exceeds the depth, so this guard also saturates wr_count.
            if (wr_count_q != len_q) begin
              we_s       = 1'b1;
              wr_count_d = wr_count_q + (AW+1)'(1);
              dec_cnt_d  = decim_q;
              if (wr_count_d == len_q) begin
                state_d = ST_DONE;
              end else begin
                state_d = ST_CAPTURE;
              end
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            dec_cnt_d = dec_cnt_q - DECW'(1);
          end
        end else begin
          state_d = ST_CAPTURE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort only redirects the state; a write in the same cycle still lands.
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_d;
    end

    busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  // FSM state, counters and registered status outputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      decim_q    <= '0;
      dec_cnt_q  <= '0;
      wr_count_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UC_CAPTURE_TRIG_EN
      prev_x_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      decim_q    <= decim_d;
      dec_cnt_q  <= dec_cnt_d;
      wr_count_q <= wr_count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UC_CAPTURE_TRIG_EN
      prev_x_q   <= prev_x_d;
`endif
    end
  end

  uc_capture_ram #(
    .WW (2*DW),
    .AW (AW)
  ) u_ram (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .we    (we_s),
    .waddr (wr_count_q[AW-1:0]),
    .wdata ({in_x, in_y}),
    .raddr (rd_addr),
    .rdata (rd_data_s)
  );

  assign rd_x     = rd_data_s[2*DW-1:DW];
  assign rd_y     = rd_data_s[DW-1:0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_uc_rx_capture.sv
// -----------------------------------------------------------------------------
// tb_uc_rx_capture
// Self-checking bench for uc_rx_capture: a table of capture scenarios, random
// captures against a sample-list reference model, and hand-written sequences
// for abort, start/abort races, asynchronous reset and (when built with
// UC_CAPTURE_TRIG_EN) the level trigger.
// -----------------------------------------------------------------------------
module tb_uc_rx_capture;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DECW  = 8;
  localparam int DEPTH = 1024;

  logic                 sys_clk = 1'b0;
  logic                 rst_n;
  logic                 ce_down;
  logic signed [DW-1:0] in_x;
  logic signed [DW-1:0] in_y;
  logic                 start;
  logic                 abort;
  logic [AW:0]          cap_len;
  logic [DECW-1:0]      decim;
  logic [AW-1:0]        rd_addr;
  logic signed [DW-1:0] rd_x;
  logic signed [DW-1:0] rd_y;
  logic                 busy;
  logic                 done;
  logic [AW:0]          wr_count;
`ifdef UC_CAPTURE_TRIG_EN
  logic signed [DW-1:0] trig_level;
  logic                 trig_slope;
`endif

  int total = 0;
  int bad   = 0;

  // Reference picture of the RAM: what software should read back at each address.
  logic [2*DW-1:0] mem_m [DEPTH];
  bit              mem_v [DEPTH];

  typedef struct {
    int len_in;
    int dec;
    int period;   // ce_down every 'period' cycles; 0 = random
    bit ramp;     // data x=n, y=-n, else random
    int exp_len;  // expected final wr_count
  } vec_t;

  vec_t tbl [6];

  uc_rx_capture #(.DW(DW), .AW(AW), .DECW(DECW)) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .ce_down  (ce_down),
    .in_x     (in_x),
    .in_y     (in_y),
    .start    (start),
    .abort    (abort),
    .cap_len  (cap_len),
    .decim    (decim),
    .rd_addr  (rd_addr),
    .rd_x     (rd_x),
    .rd_y     (rd_y),
    .busy     (busy),
    .done     (done),
    .wr_count (wr_count)
`ifdef UC_CAPTURE_TRIG_EN
    ,
    .trig_level (trig_level),
    .trig_slope (trig_slope)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, $signed(act), act, $signed(exp), exp, $time);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic readback(input int a);
    rd_addr = AW'(a);
    step();
    chk($sformatf("readback[%0d]", a), 64'({rd_x, rd_y}), 64'(mem_m[a]));
  endtask

  // One complete capture: start, feed samples until the model says the block
  // is full, confirm later samples are dropped, then read the buffer back.
  task automatic run_capture(input vec_t v);
    int seen, stored, cyc, n;
    bit ce, ok5;
    logic [DW-1:0] x, y;
    logic [2*DW-1:0] old5;

    cap_len = (AW+1)'(v.len_in);
    decim   = DECW'(v.dec);
    rd_addr = AW'(5);
    start   = 1'b1;
    ce_down = 1'b0;
    step();
    chk("armed_busy", 64'(busy), 64'(1));
    chk("armed_count", 64'(wr_count), 64'(0));
    // A sample on the ARMED->CAPTURE edge must not be stored.
    start   = 1'b0;
    ce_down = 1'b1;
    in_x    = 16'sh7bad;
    in_y    = 16'sh5eed;
    step();
    chk("capture_entry_count", 64'(wr_count), 64'(0));

    seen = 0; stored = 0; cyc = 0; n = 0;
    while (stored < v.exp_len && cyc < 20000) begin
      cyc++;
      ce = (v.period > 0) ? ((cyc % v.period) == 0) : ($urandom_range(0, 1) == 1);
      if (v.ramp) begin
        x = DW'(n + 1);
        y = DW'(-(n + 1));
      end else begin
        x = DW'($urandom);
        y = DW'($urandom);
      end
      ce_down = ce;
      in_x    = x;
      in_y    = y;
      ok5     = mem_v[5];
      old5    = mem_m[5];
      if (ce) begin
        if ((seen % (v.dec + 1)) == 0) begin
          mem_m[stored] = {x, y};
          mem_v[stored] = 1'b1;
          stored++;
        end
        seen++;
        n++;
      end
      step();
      if (ok5) chk("read_first_addr5", 64'({rd_x, rd_y}), 64'(old5));
      chk("wr_count", 64'(wr_count), 64'(stored));
      chk("done", 64'(done), 64'(stored == v.exp_len));
      chk("busy", 64'(busy), 64'(stored != v.exp_len));
    end
    chk("capture_finished", 64'(stored), 64'(v.exp_len));

    // Samples after completion are dropped and wr_count neither moves nor wraps.
    for (int i = 0; i < 12; i++) begin
      ce_down = 1'b1;
      in_x    = v.ramp ? DW'(n + 1) : DW'($urandom);
      in_y    = v.ramp ? DW'(-(n + 1)) : DW'($urandom);
      n++;
      step();
      chk("post_done_count", 64'(wr_count), 64'(v.exp_len));
      chk("post_done_flag", 64'(done), 64'(1));
    end
    ce_down = 1'b0;

    for (int a = 0; a < v.exp_len + 2 && a < DEPTH; a++) begin
      if (mem_v[a]) readback(a);
    end
    if (v.ramp) begin
      // Address k holds sample k*(decim+1)+1 of the ramp.
      rd_addr = AW'(v.exp_len - 1);
      step();
      chk("ramp_last_x", 64'(rd_x), 64'((v.exp_len - 1) * (v.dec + 1) + 1));
      chk("ramp_last_y", 64'(rd_y), 64'(-((v.exp_len - 1) * (v.dec + 1) + 1)));
    end
  endtask

  task automatic feed(input int cnt, input int base, inout int stored);
    for (int i = 0; i < cnt; i++) begin
      ce_down = 1'b1;
      in_x    = DW'(base + i);
      in_y    = DW'(-(base + i));
      mem_m[stored] = {in_x, in_y};
      mem_v[stored] = 1'b1;
      stored++;
      step();
    end
    ce_down = 1'b0;
  endtask

  initial begin
    int stored;
    vec_t rv;

    rst_n   = 1'b0;
    ce_down = 1'b0;
    in_x    = '0;
    in_y    = '0;
    start   = 1'b0;
    abort   = 1'b0;
    cap_len = '0;
    decim   = '0;
    rd_addr = '0;
`ifdef UC_CAPTURE_TRIG_EN
    trig_level = '0;
    trig_slope = 1'b0;
`endif
    #12;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_count", 64'(wr_count), 64'(0));
    chk("reset_rd", 64'({rd_x, rd_y}), 64'(0));
    @(negedge sys_clk);
    rst_n = 1'b1;
    step();

`ifdef UC_CAPTURE_TRIG_EN
    // Rising trigger at 100: first stored x is 120.
    trig_level = 16'sd100;
    trig_slope = 1'b0;
    cap_len = (AW+1)'(3);
    decim   = '0;
    start   = 1'b1;
    step();
    start = 1'b0;
    foreach (tbl[i]) tbl[i] = '{0, 0, 0, 1'b0, 0};
    begin
      int seq [5] = '{50, 90, 120, 80, 130};
      for (int i = 0; i < 5; i++) begin
        ce_down = 1'b1; in_x = DW'(seq[i]); in_y = DW'(i); step();
      end
      ce_down = 1'b0;
      chk("trig_rise_count", 64'(wr_count), 64'(3));
      chk("trig_rise_done", 64'(done), 64'(1));
      rd_addr = '0; step();
      chk("trig_rise_first_x", 64'(rd_x), 64'(120));
      rd_addr = AW'(2); step();
      chk("trig_rise_third_x", 64'(rd_x), 64'(130));
      // Fresh reset clears the previous-sample register before the falling test.
      rst_n = 1'b0; #2; rst_n = 1'b1;
      step();
      trig_slope = 1'b1;
      cap_len = (AW+1)'(2);
      start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 5; i++) begin
        ce_down = 1'b1; in_x = DW'(seq[i]); in_y = DW'(i); step();
      end
      ce_down = 1'b0;
      chk("trig_fall_count", 64'(wr_count), 64'(2));
      rd_addr = '0; step();
      chk("trig_fall_first_x", 64'(rd_x), 64'(80));
    end
`else
    // Capture scenarios: {cap_len, decim, ce period, ramp, expected length}.
    tbl[0] = '{8,    0, 4, 1'b1, 8};
    tbl[1] = '{0,    2, 1, 1'b1, 1024};
    tbl[2] = '{2000, 0, 1, 1'b1, 1024};
    tbl[3] = '{1,    0, 2, 1'b0, 1};
    tbl[4] = '{37,   3, 0, 1'b0, 37};
    tbl[5] = '{1025, 1, 1, 1'b1, 1024};
    for (int i = 0; i < 6; i++) run_capture(tbl[i]);

    // Abort mid-capture after 40 stored pairs.
    cap_len = (AW+1)'(100);
    decim   = '0;
    start   = 1'b1; step();
    start   = 1'b0; step();
    stored  = 0;
    feed(40, 1000, stored);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_count", 64'(wr_count), 64'(40));
    ce_down = 1'b1; in_x = 16'sd77; step(); ce_down = 1'b0;
    chk("idle_drops_sample", 64'(wr_count), 64'(40));

    // start+abort together: abort wins, nothing is cleared.
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    chk("race_busy", 64'(busy), 64'(0));
    chk("race_count", 64'(wr_count), 64'(40));

    // A lone start clears wr_count.
    start = 1'b1; step(); start = 1'b0;
    chk("restart_count", 64'(wr_count), 64'(0));
    chk("restart_busy", 64'(busy), 64'(1));
    step();
    stored = 0;
    feed(5, 2000, stored);
    chk("cap_count5", 64'(wr_count), 64'(5));
    // start during CAPTURE is ignored; the sample in that cycle still counts.
    start = 1'b1;
    feed(1, 2005, stored);
    start = 1'b0;
    chk("start_ignored_count", 64'(wr_count), 64'(6));
    chk("start_ignored_busy", 64'(busy), 64'(1));
    rd_addr = '0;
    feed(2, 2006, stored);
    chk("cap_count8", 64'(wr_count), 64'(8));
    chk("rd_before_reset", 64'({rd_x, rd_y}), 64'(mem_m[0]));

    // Asynchronous reset in the middle of a cycle.
    @(posedge sys_clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_done", 64'(done), 64'(0));
    chk("async_rst_count", 64'(wr_count), 64'(0));
    chk("async_rst_rd", 64'({rd_x, rd_y}), 64'(0));
    step();
    rst_n = 1'b1;
    step();

    // Random captures against the sample-list model.
    for (int i = 0; i < 5; i++) begin
      rv.len_in  = $urandom_range(1, 60);
      rv.dec     = $urandom_range(0, 3);
      rv.period  = 0;
      rv.ramp    = 1'b0;
      rv.exp_len = rv.len_in;
      run_capture(rv);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uc_rx_capture.md
Name: uc_rx_capture

Overview:
- Block-capture buffer directly downstream of the RX channel's decimated output (downsampled x/y, qualified by ce_down).
- On a CPU start pulse it stores a programmable number of x/y sample pairs into on-chip RAM, optionally decimating further.
- The CPU then reads the buffer back by address through CSRs.
- Gives software coherent, gap-free sample blocks at the downsampled rate, which CSR polling cannot guarantee.

Parameters:
- DW, 16, sample width of x and y (signed).
- AW, 10, RAM address width; depth = 2**AW pairs.
- DECW, 8, width of the extra decimation factor.

Ports:
- sys_clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- ce_down  in  1  sample-valid strobe from the RX channel, one cycle wide.
- in_x  in  DW  signed downsampled I.
- in_y  in  DW  signed downsampled Q.
- start  in  1  one-cycle pulse; begins a capture.
- abort  in  1  one-cycle pulse; returns to IDLE.
- cap_len  in  AW+1  pairs to capture; 0 means 2**AW; values above 2**AW are clamped to 2**AW.
- decim  in  DECW  keep one ce_down sample in every decim+1.
- rd_addr  in  AW  CPU read address.
- rd_x  out  DW  RAM word x at rd_addr, 1-cycle latency.
- rd_y  out  DW  RAM word y at rd_addr, 1-cycle latency.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- wr_count  out  AW+1  pairs written in the current or last capture.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, wr_count=0, rd_x=rd_y=0, decimation counter=0. RAM contents are undefined.
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE --start--> ARMED without UC_CAPTURE_TRIG_EN, otherwise waits for the trigger.
  - Without the trigger option, ARMED advances to CAPTURE on the next cycle.
  - On start: latch cap_len and decim, clear wr_count and the decimation counter.
- CAPTURE, on each ce_down:
  - If dec_cnt==0: write {in_x,in_y} at address wr_count[AW-1:0], increment wr_count, reload dec_cnt=decim_latched.
  - Otherwise decrement dec_cnt.
  - When the increment reaches the latched length: go to DONE in the same cycle as the last write.
- DONE stays until start (new capture, wr_count cleared) or abort (go to IDLE, wr_count held).
- abort in any state: go to IDLE next cycle. Any write in that cycle is still performed.
- Simultaneous events:
  - start+abort: abort wins.
  - start while ARMED/CAPTURE: ignored.
  - ce_down in the cycle of the state change into CAPTURE: not sampled; the first sample taken is the next ce_down.
- decim=0: every ce_down is stored.
- wr_count saturates at 2**AW and never wraps. Addressing uses the low AW bits only.
- rd_x/rd_y register the RAM output. Same-address read/write in one cycle returns the old data (read-first).
- The block never back-pressures ce_down. Samples arriving outside CAPTURE are dropped silently.
- in_x/in_y are stored unmodified; no scaling.

Optional Feature:
- Macro UC_CAPTURE_TRIG_EN.
- When defined, extra inputs are added:
  - trig_level (DW, signed)
  - trig_slope (1; 0=rising, 1=falling)
- ARMED then waits for a ce_down sample on which in_x crosses trig_level:
  - rising: previous < level and current >= level.
  - falling: previous > level and current <= level.
- The previous-sample register resets to 0 and updates on every ce_down while ARMED.
- The crossing sample itself is the first sample written; its ce_down counts as decimation phase 0.
- When undefined: ports absent, ARMED lasts exactly one cycle.

Decomposition:
- Package uc_capture_pkg:
  - state enum (IDLE=0, ARMED=1, CAPTURE=2, DONE=3)
  - DEPTH = 2**AW helper
  - the length-clamp function
- Sub-module uc_capture_ram: simple dual-port, one write port and one registered read port, read-first, 2*DW wide, depth 2**AW. Inferable as block RAM.
- The FSM, counters and trigger live in uc_rx_capture.

Test Plan:
- Basic capture: cap_len=8, decim=0, ce_down every 4 cycles, in_x=n, in_y=-n for n=1..20.
  - Required: done after the 8th stored sample, wr_count=8.
  - rd_addr 0..7 returns x=1..8 / y=-1..-8 with 1-cycle latency.
  - Samples 9..20 are not stored.
- Decimation and full depth: cap_len=0, decim=2, ramp input.
  - Required: 1024 pairs are stored.
  - Address k holds sample 3k+1, counting from the first sample accepted after CAPTURE entry.
  - wr_count=1024 and does not wrap.
- Abort mid-capture: cap_len=100, abort after 40 stored.
  - Required: IDLE next cycle, busy=0, done=0, wr_count=40.
  - A subsequent start clears wr_count to 0.
- Races and reset:
  - start+abort in the same cycle: stays IDLE.
  - start during CAPTURE: ignored, count continues.
  - rst_n pulled low mid-capture: all outputs go to their reset values immediately, asynchronously.
- Clamp and read-first:
  - cap_len=2000: clamped to 1024.
  - Reading address 5 in the cycle that writes address 5 returns the previous contents.
- Trigger (UC_CAPTURE_TRIG_EN): trig_level=100, rising, in_x sequence 50,90,120,80,130.
  - Required: the first stored x is 120.
  - With falling slope, the first stored x is 80.
